// File: rtl/compound_op_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : compound_op_pkg
//  Brief   : Shared types for the compound-assignment sequencer: opcode and
//            FSM state enumerations plus opcode classification helpers.
//  Rev     : 1.0  initial release
// ============================================================================
package compound_op_pkg;

  // Operator codes; 12..15 are reserved and treated as illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ASHL = 4'd10,
    OP_ASHR = 4'd11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Any code above the last defined operator is reserved.
  function automatic logic is_illegal(input op_e op);
    return (4'(op) > 4'd11);
  endfunction

  // Operators that need the iterative divider.
  function automatic logic is_divide(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/compound_op_divider.sv
`default_nettype none
// ============================================================================
//  Module  : compound_op_divider
//  Brief   : Restoring unsigned divider, one quotient bit per cycle. The first
//            bit is resolved on the start edge so that done pulses exactly
//            WIDTH cycles after start is presented.
//  Rev     : 1.0  initial release
// ============================================================================
module compound_op_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int C_CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   div_q;
  logic [C_CNT_W-1:0] cnt_q;
  logic               run_q;
  logic               done_q;

  logic [WIDTH-1:0] w_src_rem;
  logic [WIDTH-1:0] w_src_quo;
  logic [WIDTH-1:0] w_src_div;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;

  // One restoring step; on start the step operates on the fresh operands.
  always_comb begin
    w_src_rem = start ? '0       : rem_q;
    w_src_quo = start ? dividend : quo_q;
    w_src_div = start ? divisor  : div_q;
    w_shift   = {w_src_rem, w_src_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, w_src_div};
    w_ge      = ~w_diff[WIDTH];
    w_rem_n   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_n   = {w_src_quo[WIDTH-2:0], w_ge};
  end

  // Iteration registers; quo_q shifts dividend bits out and quotient bits in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= w_rem_n;
      quo_q  <= w_quo_n;
      div_q  <= divisor;
      cnt_q  <= C_CNT_W'(WIDTH - 1);
      run_q  <= (WIDTH > 1);
      done_q <= (WIDTH == 1);
    end else if (run_q) begin
      rem_q  <= w_rem_n;
      quo_q  <= w_quo_n;
      cnt_q  <= cnt_q - C_CNT_W'(1);
      run_q  <= (cnt_q != C_CNT_W'(1));
      done_q <= (cnt_q == C_CNT_W'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/compound_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : compound_op_sequencer
//  Brief   : Executes reg = reg OP operand on a small accumulator file, one
//            command per handshake, returning the new value on a response
//            handshake. DIV/MOD use the iterative divider.
//  Rev     : 1.0  initial release
// ============================================================================
module compound_op_sequencer
  import compound_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_idx,
  input  logic [WIDTH-1:0]         cmd_operand,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(NREGS)-1:0] rsp_idx,
  output logic                     rsp_err,
  output logic                     busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]         regs_q [NREGS];
  logic [WIDTH-1:0]         rsp_data_q, rsp_data_d;
  logic [$clog2(NREGS)-1:0] rsp_idx_q,  rsp_idx_d;
  logic                     rsp_err_q,  rsp_err_d;
  logic [$clog2(NREGS)-1:0] pend_idx_q;
  logic                     pend_mod_q;

  op_e                      w_op;
  logic                     w_accept;
  logic                     w_div_start;
  logic [WIDTH-1:0]         w_old_val;
  logic [WIDTH-1:0]         w_alu_res;
  logic                     w_alu_err;
  logic                     w_shift_big;
  logic                     w_wr_en;
  logic [$clog2(NREGS)-1:0] w_wr_idx;
  logic [WIDTH-1:0]         w_wr_data;
  logic                     w_div_done;
  logic [WIDTH-1:0]         w_quotient;
  logic [WIDTH-1:0]         w_remainder;

  assign w_op        = op_e'(cmd_op);
  assign w_accept    = cmd_valid && (state_q == IDLE);
  assign w_old_val   = regs_q[cmd_idx];
  // A zero divisor never starts the divider; it is reported from the ALU path.
  assign w_div_start = w_accept && is_divide(w_op) && (cmd_operand != '0);

  compound_op_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (w_old_val),
    .divisor   (cmd_operand),
    .done      (w_div_done),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

  // Single-cycle ALU; errors leave the result equal to the old register value.
  always_comb begin
    w_alu_res   = w_old_val;
    w_alu_err   = 1'b0;
    w_shift_big = (32'(cmd_operand) >= 32'(WIDTH));
    if (is_illegal(w_op)) begin
      w_alu_err = 1'b1;
    end else begin
      case (w_op)
        OP_ADD:  w_alu_res = w_old_val + cmd_operand;
        OP_SUB:  w_alu_res = w_old_val - cmd_operand;
        OP_MUL:  w_alu_res = w_old_val * cmd_operand;
        OP_DIV,
        OP_MOD:  w_alu_err = (cmd_operand == '0);
        OP_AND:  w_alu_res = w_old_val & cmd_operand;
        OP_OR:   w_alu_res = w_old_val | cmd_operand;
        OP_XOR:  w_alu_res = w_old_val ^ cmd_operand;
        OP_SHL,
        OP_ASHL: w_alu_res = w_shift_big ? '0 : (w_old_val << cmd_operand);
        OP_SHR:  w_alu_res = w_shift_big ? '0 : (w_old_val >> cmd_operand);
        OP_ASHR: w_alu_res = w_shift_big ? {WIDTH{w_old_val[WIDTH-1]}}
                                         : WIDTH'($signed(w_old_val) >>> cmd_operand);
        default: w_alu_err = 1'b1;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid)  state_d = w_div_start ? DIV : RESP;
      DIV:  if (w_div_done) state_d = RESP;
      RESP: if (rsp_ready)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Register-file write port and response loading for both completion paths.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_idx   = cmd_idx;
    w_wr_data  = w_alu_res;
    rsp_data_d = rsp_data_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_err_d  = rsp_err_q;
    if (w_accept && !w_div_start) begin
      w_wr_en    = ~w_alu_err;
      rsp_data_d = w_alu_res;
      rsp_idx_d  = cmd_idx;
      rsp_err_d  = w_alu_err;
    end else if ((state_q == DIV) && w_div_done) begin
      w_wr_en    = 1'b1;
      w_wr_idx   = pend_idx_q;
      w_wr_data  = pend_mod_q ? w_remainder : w_quotient;
      rsp_data_d = w_wr_data;
      rsp_idx_d  = pend_idx_q;
      rsp_err_d  = 1'b0;
    end
  end

  // Accumulator file, response holding registers and in-flight divide context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rsp_data_q <= '0;
      rsp_idx_q  <= '0;
      rsp_err_q  <= 1'b0;
      pend_idx_q <= '0;
      pend_mod_q <= 1'b0;
    end else begin
      if (w_wr_en) regs_q[w_wr_idx] <= w_wr_data;
      rsp_data_q <= rsp_data_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_err_q  <= rsp_err_d;
      if (w_div_start) begin
        pend_idx_q <= cmd_idx;
        pend_mod_q <= (w_op == OP_MOD);
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_idx  = rsp_idx_q;
  assign rsp_err  = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_compound_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_compound_op_sequencer
//  Brief   : Directed, table-driven bench for compound_op_sequencer
//            (WIDTH=8, NREGS=4) plus hand-written backpressure and
//            reset-during-divide sequences.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_compound_op_sequencer;
  import compound_op_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'd0;
  logic [1:0] cmd_idx = 2'd0;
  logic [7:0] cmd_operand = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [1:0] rsp_idx;
  logic       rsp_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] op;
    logic [1:0] idx;
    logic [7:0] opd;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  compound_op_sequencer #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .cmd_operand (cmd_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_idx     (rsp_idx),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, " rsp_idx"},   32'(rsp_idx),   32'd0);
    chk({tag, " rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // Issue one command (rsp_ready high), measure latency, check the response
  // and that the block is back in IDLE one edge after the response.
  task automatic run_cmd(input vec_t v, input int k);
    int   lat;
    int   guard;
    logic ready_leak;
    string tag;
    tag = $sformatf("v%0d", k);
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_idx     = v.idx;
    cmd_operand = v.opd;
    @(posedge clk);
    #1;
    // Scramble inputs: they must be ignored while the command is in flight.
    cmd_valid   = 1'b0;
    cmd_op      = 4'd0;
    cmd_idx     = ~v.idx;
    cmd_operand = 8'h5A;
    lat = 1;
    ready_leak = 1'b0;
    while (!rsp_valid && lat < 50) begin
      if (cmd_ready || !busy) ready_leak = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (cmd_ready || !busy) ready_leak = 1'b1;
    chk({tag, " latency"},   32'(lat),        32'(v.exp_lat));
    chk({tag, " rsp_data"},  32'(rsp_data),   32'(v.exp_data));
    chk({tag, " rsp_err"},   32'(rsp_err),    32'(v.exp_err));
    chk({tag, " rsp_idx"},   32'(rsp_idx),    32'(v.idx));
    chk({tag, " ready_low"}, 32'(ready_leak), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " back_idle"}, {30'd0, cmd_ready, rsp_valid}, 32'b10);
  endtask

  initial begin
    // op, idx, operand, expected data, expected err, latency in cycles
    vecs.push_back('{4'(OP_ADD),  2'd0, 8'h05, 8'h05, 1'b0, 1});
    vecs.push_back('{4'(OP_SUB),  2'd0, 8'h07, 8'hFE, 1'b0, 1});
    vecs.push_back('{4'(OP_MUL),  2'd0, 8'h03, 8'hFA, 1'b0, 1});
    vecs.push_back('{4'(OP_ADD),  2'd1, 8'hFE, 8'hFE, 1'b0, 1});
    vecs.push_back('{4'(OP_DIV),  2'd1, 8'h03, 8'h54, 1'b0, 9});
    vecs.push_back('{4'(OP_DIV),  2'd1, 8'h00, 8'h54, 1'b1, 1});
    vecs.push_back('{4'(OP_MOD),  2'd1, 8'h05, 8'h04, 1'b0, 9});
    vecs.push_back('{4'd13,       2'd1, 8'h00, 8'h04, 1'b1, 1});
    vecs.push_back('{4'(OP_ADD),  2'd1, 8'h00, 8'h04, 1'b0, 1});
    vecs.push_back('{4'(OP_ADD),  2'd2, 8'h80, 8'h80, 1'b0, 1});
    vecs.push_back('{4'(OP_ASHR), 2'd2, 8'h09, 8'hFF, 1'b0, 1});
    vecs.push_back('{4'(OP_ADD),  2'd3, 8'h80, 8'h80, 1'b0, 1});
    vecs.push_back('{4'(OP_SHR),  2'd3, 8'h09, 8'h00, 1'b0, 1});
    vecs.push_back('{4'(OP_ADD),  2'd3, 8'h80, 8'h80, 1'b0, 1});
    vecs.push_back('{4'(OP_SHL),  2'd3, 8'h01, 8'h00, 1'b0, 1});
    vecs.push_back('{4'(OP_AND),  2'd0, 8'h0F, 8'h0A, 1'b0, 1});
    vecs.push_back('{4'(OP_OR),   2'd0, 8'h50, 8'h5A, 1'b0, 1});
    vecs.push_back('{4'(OP_XOR),  2'd0, 8'hFF, 8'hA5, 1'b0, 1});
    vecs.push_back('{4'(OP_ASHL), 2'd0, 8'h03, 8'h28, 1'b0, 1});
    vecs.push_back('{4'(OP_SHR),  2'd0, 8'h03, 8'h05, 1'b0, 1});
    vecs.push_back('{4'(OP_SHL),  2'd0, 8'h08, 8'h00, 1'b0, 1});
    vecs.push_back('{4'(OP_SUB),  2'd2, 8'h7F, 8'h80, 1'b0, 1});
    vecs.push_back('{4'(OP_ASHR), 2'd2, 8'h02, 8'hE0, 1'b0, 1});
    vecs.push_back('{4'(OP_ASHR), 2'd2, 8'hFF, 8'hFF, 1'b0, 1});
    vecs.push_back('{4'(OP_ADD),  2'd3, 8'hFF, 8'hFF, 1'b0, 1});
    vecs.push_back('{4'(OP_DIV),  2'd3, 8'h01, 8'hFF, 1'b0, 9});
    vecs.push_back('{4'(OP_MOD),  2'd3, 8'h00, 8'hFF, 1'b1, 1});
    vecs.push_back('{4'(OP_ADD),  2'd0, 8'h07, 8'h07, 1'b0, 1});
    vecs.push_back('{4'(OP_MOD),  2'd0, 8'h09, 8'h07, 1'b0, 9});
    vecs.push_back('{4'(OP_DIV),  2'd0, 8'h09, 8'h00, 1'b0, 9});
    vecs.push_back('{4'd15,       2'd2, 8'h00, 8'hFF, 1'b1, 1});
    vecs.push_back('{4'(OP_SUB),  2'd1, 8'h05, 8'hFF, 1'b0, 1});
    vecs.push_back('{4'(OP_MUL),  2'd1, 8'hFF, 8'h01, 1'b0, 1});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) run_cmd(vecs[k], k);

    // Backpressure: XOR r0 (currently 0) with FF, hold rsp_ready low.
    @(negedge clk);
    rsp_ready   = 1'b0;
    cmd_valid   = 1'b1;
    cmd_op      = 4'(OP_XOR);
    cmd_idx     = 2'd0;
    cmd_operand = 8'hFF;
    @(posedge clk);
    #1;
    // Offer a competing command for the whole stall; it must not be taken.
    cmd_op      = 4'(OP_ADD);
    cmd_operand = 8'h01;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d state", c), {29'd0, rsp_valid, cmd_ready, busy}, 32'b101);
      chk($sformatf("bp%0d data", c), {21'd0, rsp_err, rsp_idx, rsp_data}, {21'd0, 1'b0, 2'd0, 8'hFF});
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp release", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    run_cmd('{4'(OP_ADD), 2'd0, 8'h00, 8'hFF, 1'b0, 1}, 100);

    // Reset in the middle of a divide on r1 (= 01).
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = 4'(OP_DIV);
    cmd_idx     = 2'd1;
    cmd_operand = 8'h01;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-div busy", {30'd0, busy, cmd_ready}, 32'b10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      repeat (12) begin
        @(posedge clk);
        #1;
        if (rsp_valid || busy) seen_valid = 1'b1;
      end
      chk("no stale divide", 32'(seen_valid), 32'd0);
    end
    for (int r = 0; r < NREGS; r++)
      run_cmd('{4'(OP_ADD), 2'(r), 8'h00, 8'h00, 1'b0, 1}, 200 + r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/compound_op_sequencer.md
# compound_op_sequencer

Sequential execution unit for SystemVerilog compound-assignment operators (`+=`, `-=`, `*=`, `/=`, `%=`, `&=`, `|=`, `^=`, `<<=`, `>>=`, `<<<=`, `>>>=`).

- Holds a small accumulator register file.
- Accepts one command per handshake: operator, target register and operand.
- Applies `reg = reg OP operand` and returns the new value on a response handshake.
- Sits between a command source (test sequencer or CPU-side shim) and any consumer of the results.
- Divide and modulo run on an iterative divider; all other operators complete in one cycle.

## Interface

Parameters:
- `WIDTH`, 8: data and register width.
- `NREGS`, 4: number of accumulator registers (power of two, ≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 4: operator code; see Operation.
- `cmd_idx` in `$clog2(NREGS)`: target register.
- `cmd_operand` in `WIDTH`: right-hand operand.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_data` out `WIDTH`: register value after the operation.
- `rsp_idx` out `$clog2(NREGS)`: register that was written.
- `rsp_err` out 1: divide/modulo by zero, or illegal opcode.
- `busy` out 1: high in any state other than IDLE.

## Operation

Opcodes:
- 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR.
- 8 SHL, 9 SHR, 10 ASHL, 11 ASHR.
- 12–15 are illegal.

Arithmetic and width rules:
- All operands are unsigned, except that ASHR treats `reg` as signed.
- Results are truncated to `WIDTH`, so ADD, SUB and MUL wrap modulo 2^WIDTH.
- Shift amount is the full `cmd_operand` value.
- If the shift amount is ≥ `WIDTH`:
  - SHL, SHR and ASHL produce 0.
  - ASHR produces all copies of the sign bit.
- ASHL is identical to SHL.

Error cases:
- DIV by 0: register unchanged, `rsp_data` = old value, `rsp_err`=1. There is no divider run; the block goes straight to RESP.
- MOD by 0: same as DIV by 0.
- Illegal opcode: register unchanged, `rsp_data` = old value, `rsp_err`=1.

State machine (states IDLE, DIV, RESP):
- IDLE: `cmd_ready`=1.
  - On accept with DIV or MOD and a nonzero operand: start the divider, go to DIV.
  - On any other accept: compute, write the register, load the response, go to RESP.
- DIV: wait for divider done, which comes after exactly `WIDTH` cycles.
  - Write the quotient (DIV) or remainder (MOD) to the register.
  - Load the response, go to RESP.
- RESP: `rsp_valid`=1; `rsp_data`, `rsp_idx` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.

Boundary conditions:
- No command overlap: `cmd_ready`=0 in DIV and RESP.
- Inputs are sampled only on the accept edge. `cmd_*` changes during DIV or RESP are ignored.
- Reset mid-operation (any state): state → IDLE, all registers → 0, divider aborted, in-flight command discarded.

## Timing

Reset values:
- `cmd_ready`=1
- `rsp_valid`=0
- `rsp_data`=0
- `rsp_idx`=0
- `rsp_err`=0
- `busy`=0
- all registers = 0

Latency, for a command accepted on edge N:
- Single-cycle op: register updated and `rsp_valid`=1 after edge N+1.
- DIV/MOD with nonzero divisor: `rsp_valid`=1 after edge N+1+`WIDTH`.
- Peak throughput: one single-cycle command every 2 cycles, when `rsp_ready` is held high.
- `cmd_ready`/`busy` are registered from state and never combinationally depend on `rsp_ready`.
- Backpressure: a low `rsp_ready` stalls in RESP indefinitely, with the response held unchanged.

## Structure

Package `compound_op_pkg`:
- `op_e` enum, 4-bit, with the opcode values above.
- `state_e` enum: IDLE, DIV, RESP.
- Function `is_illegal(op_e)`.

Sub-module `compound_op_divider`:
- Restoring unsigned divider, one quotient bit per cycle.
- Ports: `clk`, `rst`, `start`, `dividend`, `divisor`, `done`, `quotient`, `remainder`.
- `done` is a one-cycle pulse exactly `WIDTH` cycles after `start`.

The top level holds the FSM, the register file, the single-cycle ALU and the response registers.

## Test plan

All scenarios use WIDTH=8, NREGS=4.

1. After reset, r0=0. ADD 5 → `rsp_data`=0x05. SUB 7 → 0xFE. MUL 3 → 0xFA (wrap). Each `rsp_valid` asserts one cycle after accept.
2. r1=0xFE via ADD. DIV 3 → 0x54, with `rsp_valid` 9 cycles after accept. MOD 5 → 0x04. `cmd_ready`=0 throughout.
3. r2=0x80 via ADD. ASHR 9 → 0xFF. r3=0x80: SHR 9 → 0x00; SHL 1 → 0x00.
4. DIV 0 on r1=0x54 → `rsp_data`=0x54, `rsp_err`=1, register unchanged. Opcode 13 → `rsp_err`=1, register unchanged.
5. Backpressure: hold `rsp_ready`=0 for 10 cycles after XOR 0xFF. Response stays stable, `cmd_ready` stays 0, and a new `cmd_valid` is not accepted. Raising `rsp_ready` returns to IDLE in 1 cycle.
6. Reset mid-divide: assert `rst` 4 cycles into DIV. Outputs go to reset values asynchronously, and all registers read 0 on subsequent ADD 0 commands.
